// File: rtl/mux_rot_pipe.sv
// Channel-select, rotate/shift datapath behind a two-stage valid/ready pipeline.
// Stage 1 holds the selected word and transform controls; stage 2 holds the transformed result.
module mux_rot_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH),
    parameter int AMTW  = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]        sel,
    input  logic [AMTW-1:0]        rot_amt,
    input  logic                   r_l,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sel_err
);

    typedef enum logic [1:0] {
        MODE_ROT  = 2'b00,
        MODE_LSH  = 2'b01,
        MODE_ASH  = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [AMTW-1:0]  s1_amt_q,   s1_amt_d;
    logic             s1_rl_q,    s1_rl_d;
    mode_e            s1_mode_q,  s1_mode_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             sel_err_q,   sel_err_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_bad;
    logic [WIDTH-1:0] xf_data;
    int               xf_amt;
    logic             s2_adv;
    logic             in_fire;

    // Out-of-range selects fall back to channel 0 and are flagged.
    always_comb begin
        sel_data = in_data[WIDTH-1:0];
        sel_bad  = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (int'(sel) == k) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                sel_bad  = 1'b0;
            end
        end
    end

    // Amounts past WIDTH-1 (non power-of-2 widths) wrap modulo WIDTH.
    always_comb begin
        xf_amt  = int'(s1_amt_q) % WIDTH;
        xf_data = s1_data_q;
        case (s1_mode_q)
            MODE_ROT: begin
                if (s1_rl_q)
                    xf_data = (s1_data_q << xf_amt) | (s1_data_q >> (WIDTH - xf_amt));
                else
                    xf_data = (s1_data_q >> xf_amt) | (s1_data_q << (WIDTH - xf_amt));
            end
            MODE_LSH: begin
                if (s1_rl_q)
                    xf_data = s1_data_q << xf_amt;
                else
                    xf_data = s1_data_q >> xf_amt;
            end
            MODE_ASH: begin
                if (s1_rl_q)
                    xf_data = s1_data_q << xf_amt;
                else
                    xf_data = $signed(s1_data_q) >>> xf_amt;
            end
            MODE_PASS: xf_data = s1_data_q;
            default:   xf_data = s1_data_q;
        endcase
    end

    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_adv;
        in_fire  = in_valid && in_ready;

        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_amt_d    = s1_amt_q;
        s1_rl_d     = s1_rl_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sel_err_d   = sel_err_q || (in_fire && sel_bad);

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q)
                out_data_d = xf_data;
        end

        // A new load overrides the drain, so one beat can enter while another leaves.
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = sel_data;
            s1_amt_d   = rot_amt;
            s1_rl_d    = r_l;
            s1_mode_d  = mode_e'(mode);
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_amt_q    <= '0;
            s1_rl_q     <= 1'b0;
            s1_mode_q   <= MODE_ROT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_amt_q    <= s1_amt_d;
            s1_rl_q     <= s1_rl_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_rot_pipe.sv
// Scoreboard bench for mux_rot_pipe: a WIDTH=8/NCH=4 instance under random traffic
// and a WIDTH=8/NCH=3 instance for out-of-range select behaviour.
module tb_mux_rot_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  sel;
    logic [2:0]  rot_amt;
    logic        r_l;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;

    logic [23:0] in3_data;
    logic [1:0]  sel3;
    logic [2:0]  amt3;
    logic        rl3;
    logic [1:0]  mode3;
    logic        in3_valid;
    logic        in3_ready;
    logic [7:0]  out3_data;
    logic        out3_valid;
    logic        out3_ready;
    logic        sel_err3;

    int          nCompared;
    int          nMismatched;
    logic [7:0]  expQ[$];
    int          occ;
    bit          monEn;
    bit          holdPending;
    logic [7:0]  heldData;
    bit          rdyMode;
    logic        rdyForce;

    mux_rot_pipe #(.WIDTH(8), .NCH(4)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .rot_amt(rot_amt),
        .r_l(r_l), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
    );

    mux_rot_pipe #(.WIDTH(8), .NCH(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in3_data), .sel(sel3), .rot_amt(amt3),
        .r_l(rl3), .mode(mode3), .in_valid(in3_valid), .in_ready(in3_ready),
        .out_data(out3_data), .out_valid(out3_valid), .out_ready(out3_ready), .sel_err(sel_err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bit-level reference: result bit i is taken from source bit i-n (left) or i+n (right).
    function automatic logic [7:0] refModel(input logic [7:0] d, input int amt,
                                            input bit left, input logic [1:0] m);
        logic [7:0] r;
        int n;
        n = amt % 8;
        for (int i = 0; i < 8; i++) begin
            case (m)
                2'b00: r[i] = left ? d[(i - n + 8) % 8] : d[(i + n) % 8];
                2'b01: r[i] = left ? ((i - n >= 0) ? d[(i - n + 8) % 8] : 1'b0)
                                   : ((i + n < 8) ? d[(i + n) % 8] : 1'b0);
                2'b10: r[i] = left ? ((i - n >= 0) ? d[(i - n + 8) % 8] : 1'b0)
                                   : ((i + n < 8) ? d[(i + n) % 8] : d[7]);
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one transfer from posedge+1; expectation is queued once the handshake is seen.
    task automatic applyStimulus(input logic [31:0] chans, input logic [1:0] s,
                                 input logic [2:0] a, input bit left, input logic [1:0] m);
        bit fired;
        logic [7:0] ch;
        fired = 1'b0;
        in_data  = chans;
        sel      = s;
        rot_amt  = a;
        r_l      = left;
        mode     = m;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !fired; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ch = chans[s*8 +: 8];
                expQ.push_back(refModel(ch, int'(a), left, m));
                fired = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!fired) checkOutput("input_handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic drainAll();
        rdyMode  = 1'b0;
        rdyForce = 1'b1;
        for (int t = 0; t < 100 && expQ.size() != 0; t++) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("drain_queue_empty", expQ.size(), 0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdyMode ? 1'($urandom % 2) : rdyForce;
        end
    end

    // Monitor: pops on every output handshake, checks hold-during-stall and in_ready.
    initial begin
        forever begin
            @(negedge clk);
            if (monEn && rst) begin
                checkOutput("in_ready", in_ready, !(occ == 2 && !out_ready));
                if (holdPending) begin
                    checkOutput("stall_hold_valid", out_valid, 1);
                    checkOutput("stall_hold_data", out_data, heldData);
                end
                holdPending = out_valid && !out_ready;
                heldData    = out_data;
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        nCompared++;
                        nMismatched++;
                        $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output", out_data);
                    end else begin
                        checkOutput("out_data", out_data, expQ.pop_front());
                    end
                end
                occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
            end
        end
    end

    initial begin
        logic [7:0] v;
        nCompared = 0; nMismatched = 0;
        occ = 0; monEn = 1'b0; holdPending = 1'b0; heldData = '0;
        rdyMode = 1'b0; rdyForce = 1'b1;
        rst = 1'b0;
        in_data = '0; sel = '0; rot_amt = '0; r_l = 1'b0; mode = '0; in_valid = 1'b0;
        in3_data = '0; sel3 = '0; amt3 = '0; rl3 = 1'b0; mode3 = '0; in3_valid = 1'b0;
        out3_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_sel_err", sel_err, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        monEn = 1'b1;

        applyStimulus(32'h0081_0000, 2'd2, 3'd1, 1'b1, 2'b00);
        checkOutput("latency_edge1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("latency_edge2_valid", out_valid, 1);
        checkOutput("rotl_0x81_data", out_data, 8'h03);

        applyStimulus(32'h0000_9000, 2'd1, 3'd3, 1'b0, 2'b10);
        applyStimulus(32'h0000_9000, 2'd1, 3'd3, 1'b0, 2'b01);
        applyStimulus(32'h0000_9000, 2'd1, 3'd3, 1'b0, 2'b11);
        drainAll();

        rdyMode = 1'b1;
        repeat (40) applyStimulus($urandom, 2'($urandom % 4), 3'($urandom % 8),
                                  1'($urandom % 2), 2'($urandom % 4));
        drainAll();

        rdyMode = 1'b1;
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    v = 8'(i);
                    applyStimulus({4{v}}, 2'($urandom % 4), 3'($urandom % 8), 1'($urandom % 2), 2'b11);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                rdyMode  = 1'b0;
                rdyForce = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                rdyMode = 1'b1;
            end
        join
        drainAll();
        checkOutput("sel_err_nch4", sel_err, 0);

        checkOutput("nch3_sel_err_initial", sel_err3, 0);
        in3_data  = {8'h22, 8'h11, 8'h5A};
        sel3      = 2'd3;
        mode3     = 2'b11;
        in3_valid = 1'b1;
        @(negedge clk);
        checkOutput("nch3_in_ready", in3_ready, 1);
        @(posedge clk);
        #1;
        in3_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("nch3_bad_sel_valid", out3_valid, 1);
        checkOutput("nch3_bad_sel_data", out3_data, 8'h5A);
        checkOutput("nch3_sel_err_set", sel_err3, 1);
        @(posedge clk);
        #1;
        sel3      = 2'd1;
        in3_valid = 1'b1;
        @(posedge clk);
        #1;
        in3_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("nch3_good_sel_data", out3_data, 8'h11);
        checkOutput("nch3_sel_err_sticky", sel_err3, 1);

        rdyMode  = 1'b0;
        rdyForce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(32'hA5A5_A5A5, 2'd0, 3'd0, 1'b0, 2'b11);
        applyStimulus(32'h3C3C_3C3C, 2'd0, 3'd0, 1'b0, 2'b11);
        checkOutput("full_in_ready_low", in_ready, 0);
        #3;
        monEn = 1'b0;
        rst   = 1'b0;
        #1;
        checkOutput("async_reset_out_valid", out_valid, 0);
        checkOutput("async_reset_in_ready", in_ready, 1);
        checkOutput("async_reset_sel_err3", sel_err3, 0);
        expQ.delete();
        occ = 0;
        holdPending = 1'b0;
        rdyForce = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        monEn = 1'b1;
        applyStimulus(32'h0000_00C3, 2'd0, 3'd2, 1'b0, 2'b00);
        checkOutput("post_reset_edge1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("post_reset_edge2_valid", out_valid, 1);
        checkOutput("post_reset_data", out_data, 8'hF0);
        drainAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
